// File: rtl/microwave_ctrl.sv
// microwave_ctrl: keypad entry, BCD mm:ss countdown, start/stop/door control and duty-cycled magnetron
// Ports: clock/clearn (sync active-low reset); keypad[9:0] one-hot digit keys; power_key, startn, stopn
// level inputs (edge-detected after one register stage); door_closed interlock; digits BCD time with
// sec ones in [3:0]; power_level 1..PWR_LEVELS; mag_on magnetron enable; cooking; beep end-of-cook.
module microwave_ctrl #(
  parameter int CLK_PER_SEC = 100,
  parameter int MIN_DIGITS = 1,
  parameter int PWR_LEVELS = 10,
  parameter int BEEP_SEC = 3
) (
  input  logic                          clock,
  input  logic                          clearn,
  input  logic [9:0]                    keypad,
  input  logic                          power_key,
  input  logic                          startn,
  input  logic                          stopn,
  input  logic                          door_closed,
  output logic [4*(MIN_DIGITS+2)-1:0]   digits,
  output logic [3:0]                    power_level,
  output logic                          mag_on,
  output logic                          cooking,
  output logic                          beep
);
  localparam int N = MIN_DIGITS + 2;
  localparam int PW = $clog2(CLK_PER_SEC);
  localparam int BW = $clog2(BEEP_SEC + 1);
  localparam logic [3:0] PL_MAX = 4'(PWR_LEVELS);
  localparam logic [3:0] WIN_MAX = 4'(PWR_LEVELS - 1);
  localparam logic [PW-1:0] PRE_MAX = PW'(CLK_PER_SEC - 1);
  localparam logic [BW-1:0] BEEP_MAX = BW'(BEEP_SEC - 1);
  typedef enum logic [2:0] {IDLE, SET, PWR, COOK, PAUSE, DONE} state_t;
  state_t state, state_d;
  logic [4*N-1:0] tm, tm_d, tm_dec, tm_key;
  logic [3:0] pl_d, win, win_d, key_val;
  logic [PW-1:0] pre, pre_d;
  logic [BW-1:0] bcnt, bcnt_d;
  logic [9:0] key_r, key_p;
  logic pwr_r, pwr_p, start_r, start_p, stop_r, stop_p, mag_q;
  logic key_ev, pwr_ev, start_ok, stop_ev, tick;
  // Per-digit BCD borrow chain; digit 1 is seconds tens and wraps to 5.
  function automatic logic [4*N-1:0] bcd_dec(input logic [4*N-1:0] t);
    logic [4*N-1:0] r;
    logic b;
    logic [3:0] d;
    b = 1'b1;
    for (int i = 0; i < N; i++) begin
      d = t[4*i +: 4];
      r[4*i +: 4] = !b ? d : (d == 4'd0 ? (i == 1 ? 4'd5 : 4'd9) : d - 4'd1);
      b = b && d == 4'd0;
    end
    return r;
  endfunction
  always_comb begin
    key_val = '0;
    for (int i = 0; i < 10; i++) if (key_r[i]) key_val = 4'(i);
  end
  assign key_ev = $onehot(key_r) && key_p == '0;
  assign pwr_ev = pwr_r && !pwr_p;
  assign start_ok = start_r && !start_p && door_closed;
  assign stop_ev = stop_r && !stop_p;
  assign tick = pre == PRE_MAX;
  assign tm_dec = bcd_dec(tm);
  // From SET the digit shifts in; from IDLE/DONE the time is cleared first.
  assign tm_key = state == SET ? {tm[4*N-5:0], key_val} : {{4*(N-1){1'b0}}, key_val};
  always_comb begin
    state_d = state;
    tm_d = tm;
    pl_d = power_level;
    pre_d = pre;
    win_d = win;
    bcnt_d = bcnt;
    case (state)
      IDLE, SET: begin
        if (stop_ev && state == SET) begin
          state_d = IDLE;
          tm_d = '0;
          pl_d = PL_MAX;
        end else if (start_ok) begin
          state_d = COOK;
          pre_d = '0;
          win_d = '0;
          tm_d = tm == '0 ? (4*N)'(8'h30) : tm;
        end else if (pwr_ev) state_d = PWR;
        else if (key_ev) begin
          state_d = SET;
          tm_d = tm_key;
        end
      end
      PWR: begin
        if (stop_ev) begin
          state_d = IDLE;
          tm_d = '0;
          pl_d = PL_MAX;
        end else if (key_ev && key_val <= PL_MAX) begin
          pl_d = key_val == 4'd0 ? PL_MAX : key_val;
          state_d = tm != '0 ? SET : IDLE;
        end
      end
      COOK: begin
        if (!door_closed || stop_ev) state_d = PAUSE;
        else begin
          pre_d = tick ? '0 : pre + 1'b1;
          if (tick) begin
            tm_d = tm_dec;
            win_d = win == WIN_MAX ? 4'd0 : win + 4'd1;
            if (tm_dec == '0) begin
              state_d = DONE;
              bcnt_d = '0;
            end
          end
        end
      end
      PAUSE: begin
        if (stop_ev) begin
          state_d = IDLE;
          tm_d = '0;
        end else if (start_ok) state_d = COOK;
      end
      DONE: begin
        if (stop_ev) state_d = IDLE;
        else if (key_ev) begin
          state_d = SET;
          tm_d = tm_key;
        end else begin
          pre_d = tick ? '0 : pre + 1'b1;
          if (tick) begin
            bcnt_d = bcnt + 1'b1;
            if (bcnt == BEEP_MAX) state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (!clearn) begin
      state <= IDLE;
      tm <= '0;
      power_level <= PL_MAX;
      pre <= '0;
      win <= '0;
      bcnt <= '0;
      key_r <= '0;
      key_p <= '0;
      pwr_r <= 1'b0;
      pwr_p <= 1'b0;
      start_r <= 1'b0;
      start_p <= 1'b0;
      stop_r <= 1'b0;
      stop_p <= 1'b0;
      mag_q <= 1'b0;
      cooking <= 1'b0;
      beep <= 1'b0;
    end else begin
      key_r <= keypad;
      key_p <= key_r;
      pwr_r <= power_key;
      pwr_p <= pwr_r;
      start_r <= !startn;
      start_p <= start_r;
      stop_r <= !stopn;
      stop_p <= stop_r;
      state <= state_d;
      tm <= tm_d;
      power_level <= pl_d;
      pre <= pre_d;
      win <= win_d;
      bcnt <= bcnt_d;
      mag_q <= state_d == COOK && win_d < pl_d;
      cooking <= state_d == COOK;
      beep <= state_d == DONE;
    end
  end
  // Door interlock acts combinationally so the magnetron drops the instant the door opens.
  assign mag_on = mag_q && door_closed;
  assign digits = tm;
endmodule

// File: tb/tb_microwave_ctrl.sv
// tb_microwave_ctrl: scoreboard bench for microwave_ctrl (CLK_PER_SEC=4, MIN_DIGITS=1, PWR_LEVELS=10, BEEP_SEC=2)
module tb_microwave_ctrl;
  logic clock = 1'b0, clearn, power_key, startn, stopn, door_closed;
  logic [9:0] keypad;
  logic [11:0] digits;
  logic [3:0] power_level;
  logic mag_on, cooking, beep;
  int checks = 0, failures = 0, cnt;
  typedef struct {
    string tag;
    int sig;
    logic [31:0] val;
  } exp_t;
  exp_t sb[$];
  microwave_ctrl #(.CLK_PER_SEC(4), .MIN_DIGITS(1), .PWR_LEVELS(10), .BEEP_SEC(2)) dut (
    .clock(clock), .clearn(clearn), .keypad(keypad), .power_key(power_key), .startn(startn),
    .stopn(stopn), .door_closed(door_closed), .digits(digits), .power_level(power_level),
    .mag_on(mag_on), .cooking(cooking), .beep(beep)
  );
  always #5 clock = ~clock;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask
  function automatic logic [31:0] obs(input int sig);
    case (sig)
      0: return 32'(digits);
      1: return 32'(power_level);
      2: return 32'(mag_on);
      3: return 32'(cooking);
      default: return 32'(beep);
    endcase
  endfunction
  task automatic exp_v(input string tag, input int sig, input logic [31:0] val);
    sb.push_back('{tag, sig, val});
  endtask
  task automatic drain;
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.tag, obs(e.sig), e.val);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask
  task automatic press(input logic [9:0] k, input logic s, input logic p, input logic pk);
    keypad = k;
    startn = !s;
    stopn = !p;
    power_key = pk;
    cyc(1);
    keypad = '0;
    startn = 1'b1;
    stopn = 1'b1;
    power_key = 1'b0;
    cyc(1);
  endtask
  task automatic key(input int d);
    press(10'(1 << d), 1'b0, 1'b0, 1'b0);
  endtask
  task automatic reset_state_expect(input string tag);
    exp_v({tag, "_digits"}, 0, 0);
    exp_v({tag, "_pl"}, 1, 10);
    exp_v({tag, "_mag"}, 2, 0);
    exp_v({tag, "_cooking"}, 3, 0);
    exp_v({tag, "_beep"}, 4, 0);
  endtask
  initial begin
    keypad = '0;
    power_key = 1'b0;
    startn = 1'b1;
    stopn = 1'b1;
    door_closed = 1'b1;
    clearn = 1'b0;
    reset_state_expect("reset");
    cyc(2);
    clearn = 1'b1;
    drain();
    // basic entry and countdown with full power
    exp_v("entry_105", 0, 'h105);
    key(1); key(0); key(5);
    drain();
    exp_v("start_cooking", 3, 1);
    exp_v("start_mag", 2, 1);
    exp_v("start_digits", 0, 'h105);
    press('0, 1'b1, 1'b0, 1'b0);
    drain();
    cnt = 0;
    for (int i = 0; i < 3; i++) begin cnt += int'(!mag_on); cyc(1); end
    exp_v("pre_tick_105", 0, 'h105);
    drain();
    cnt += int'(!mag_on);
    cyc(1);
    exp_v("tick_104", 0, 'h104);
    drain();
    for (int i = 0; i < 20; i++) begin cnt += int'(!mag_on); cyc(1); end
    exp_v("borrow_059", 0, 'h059);
    drain();
    check("full_power_mag_low_cycles", cnt, 0);
    exp_v("stop_pause_cooking", 3, 0);
    exp_v("stop_pause_digits", 0, 'h059);
    press('0, 1'b0, 1'b1, 1'b0);
    drain();
    exp_v("stop_idle_digits", 0, 0);
    press('0, 1'b0, 1'b1, 1'b0);
    drain();
    // SET shifting, multi-key ignore, power set, stop in SET
    exp_v("shift_234", 0, 'h234);
    key(1); key(2); key(3); key(4);
    drain();
    exp_v("multikey_ignored", 0, 'h234);
    press(10'h005, 1'b0, 1'b0, 1'b0);
    drain();
    exp_v("pwr_7", 1, 7);
    press('0, 1'b0, 1'b0, 1'b1);
    key(7);
    drain();
    exp_v("pwr_0_is_max", 1, 10);
    press('0, 1'b0, 1'b0, 1'b1);
    key(0);
    drain();
    exp_v("set_stop_digits", 0, 0);
    exp_v("set_stop_pl", 1, 10);
    press('0, 1'b0, 1'b0, 1'b1);
    key(7);
    press('0, 1'b0, 1'b1, 1'b0);
    drain();
    // duty cycle at level 4 and end-of-cook beep
    exp_v("entry_012", 0, 'h012);
    exp_v("pl_4", 1, 4);
    key(1); key(2);
    press('0, 1'b0, 1'b0, 1'b1);
    key(4);
    drain();
    press('0, 1'b1, 1'b0, 1'b0);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin cnt += int'(mag_on); cyc(1); end
    check("duty_high_cycles", cnt, 16);
    exp_v("after_10_ticks", 0, 'h002);
    exp_v("window_wrap_mag", 2, 1);
    drain();
    cyc(7);
    exp_v("last_sec_digits", 0, 'h001);
    exp_v("last_sec_beep", 4, 0);
    drain();
    cyc(1);
    exp_v("done_beep", 4, 1);
    exp_v("done_cooking", 3, 0);
    exp_v("done_mag", 2, 0);
    exp_v("done_digits", 0, 0);
    drain();
    cyc(7);
    exp_v("beep_last_cycle", 4, 1);
    drain();
    cyc(1);
    exp_v("beep_end", 4, 0);
    drain();
    // quick start, door open pause, resume with kept prescaler
    exp_v("quick_030", 0, 'h030);
    exp_v("quick_cooking", 3, 1);
    press('0, 1'b1, 1'b0, 1'b0);
    drain();
    cyc(1);
    exp_v("mag_before_door", 2, 1);
    drain();
    cyc(1);
    door_closed = 1'b0;
    #1;
    exp_v("door_mag_comb", 2, 0);
    drain();
    cyc(1);
    exp_v("door_pause", 3, 0);
    drain();
    exp_v("start_door_open_ignored", 3, 0);
    press('0, 1'b1, 1'b0, 1'b0);
    drain();
    door_closed = 1'b1;
    exp_v("resume_cooking", 3, 1);
    press('0, 1'b1, 1'b0, 1'b0);
    drain();
    cyc(1);
    exp_v("resume_pre_030", 0, 'h030);
    drain();
    cyc(1);
    exp_v("resume_tick_029", 0, 'h029);
    drain();
    press('0, 1'b0, 1'b1, 1'b0);
    exp_v("pause_stop_clear", 0, 0);
    press('0, 1'b0, 1'b1, 1'b0);
    drain();
    // 0:99 entry counting down through seconds tens above 5
    exp_v("entry_099", 0, 'h099);
    key(9); key(9);
    drain();
    press('0, 1'b1, 1'b0, 1'b0);
    cyc(4);
    exp_v("cnt_098", 0, 'h098);
    drain();
    cyc(32);
    exp_v("cnt_090", 0, 'h090);
    drain();
    cyc(4);
    exp_v("cnt_089", 0, 'h089);
    drain();
    cyc(355);
    exp_v("cnt_001", 0, 'h001);
    drain();
    cyc(1);
    exp_v("cnt_000", 0, 0);
    exp_v("cnt_done_beep", 4, 1);
    drain();
    exp_v("done_stop_beep", 4, 0);
    press('0, 1'b0, 1'b1, 1'b0);
    drain();
    // start and stop together in COOK, then reset mid-cook
    key(5);
    press('0, 1'b1, 1'b0, 1'b0);
    cyc(1);
    exp_v("start_stop_pause", 3, 0);
    exp_v("start_stop_digits", 0, 'h005);
    press('0, 1'b1, 1'b1, 1'b0);
    drain();
    exp_v("resume2_cooking", 3, 1);
    press('0, 1'b1, 1'b0, 1'b0);
    drain();
    cyc(1);
    clearn = 1'b0;
    reset_state_expect("mid_reset");
    cyc(1);
    drain();
    clearn = 1'b1;
    cyc(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
